// File: rtl/radiation_monitor_multi_channel.sv
// radiation_monitor_multi_channel
//
// Purpose:
//   Watches N SEU/TMR-mismatch lines. A rising edge on an enabled channel
//   produces a one-cycle event pulse. Each pulse is counted per channel and
//   in a running total, and sticky overflow flags are kept alongside.
//   A four-phase req/ack handshake captures all live counters into
//   snapshot registers in one edge. The same edge restarts the live counters
//   without losing any event. Snapshot values are read back through a
//   registered, addressed port.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   mismatch_i  per-channel mismatch bits, synchronous to clk_i
//   enable_i    per-channel count enable
//   clear_i     synchronous clear of live counters and overflow flags
//   snap_req_i  snapshot request (level, four-phase)
//   snap_ack_o  snapshot acknowledge
//   rd_sel_i    readout select: channel, N = total, N+1 = overflow flags
//   rd_data_o   registered readout data (1-cycle latency)
//   event_o     one-cycle pulse when any enabled channel produced an event
module radiation_monitor_multi_channel #(
  parameter int G_NUM_CHANNELS          = 8,
  parameter int G_COUNTER_WIDTH         = 16,
  parameter int G_TOTAL_WIDTH           = 24,
  parameter bit G_COUNTER_IS_SATURATING = 1'b1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [G_NUM_CHANNELS-1:0]               mismatch_i,
  input  logic [G_NUM_CHANNELS-1:0]               enable_i,
  input  logic                                    clear_i,
  input  logic                                    snap_req_i,
  output logic                                    snap_ack_o,
  input  logic [$clog2(G_NUM_CHANNELS+2)-1:0]     rd_sel_i,
  output logic [G_TOTAL_WIDTH-1:0]                rd_data_o,
  output logic                                    event_o
);

  localparam int N     = G_NUM_CHANNELS;
  localparam int W     = G_COUNTER_WIDTH;
  localparam int T     = G_TOTAL_WIDTH;
  localparam int SEL_W = $clog2(G_NUM_CHANNELS + 2);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t         state;
  logic [N-1:0]   d1;
  logic [N-1:0]   p;
  logic [N-1:0]   p_next;
  logic [W-1:0]   live_ch [N];
  logic [W-1:0]   snap_ch [N];
  logic [W-1:0]   ch_next [N];
  logic [N-1:0]   ovf;
  logic [N-1:0]   ovf_set;
  logic           ovf_total;
  logic [T-1:0]   live_total;
  logic [T-1:0]   snap_total;
  logic [T-1:0]   total_next;
  logic [T-1:0]   pop;
  logic [T:0]     total_sum;
  logic           total_carry;
  logic [N:0]     snap_ovf;
  logic           capture;
  logic [T-1:0]   rd_next;

  // Capture happens on the edge where the FSM sees a new request in IDLE.
  assign capture = (state == S_IDLE) && snap_req_i;

  // Rising-edge detect. The delay register always tracks the input, so an
  // edge that arrives while its channel is disabled is consumed, not deferred.
  assign p_next = mismatch_i & ~d1 & enable_i;

  // Edge-detect and event-pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d1      <= '0;
      p       <= '0;
      event_o <= 1'b0;
    end else begin
      d1      <= mismatch_i;
      p       <= p_next;
      event_o <= |p_next;
    end
  end

  // Next-state values for the counters during normal counting. A counter
  // that is at all-ones and receives a pulse flags overflow. It then holds
  // or wraps, depending on the mode.
  always_comb begin
    ovf_set = '0;
    pop     = '0;
    for (int c = 0; c < N; c++) begin
      ch_next[c] = live_ch[c];
      if (p[c]) begin
        if (&live_ch[c]) begin
          ovf_set[c] = 1'b1;
          ch_next[c] = G_COUNTER_IS_SATURATING ? live_ch[c] : '0;
        end else begin
          ch_next[c] = live_ch[c] + 1'b1;
        end
      end
      pop = pop + T'(p[c]);
    end
    total_sum   = {1'b0, live_total} + {1'b0, pop};
    total_carry = total_sum[T];
    if (total_carry && G_COUNTER_IS_SATURATING) begin
      total_next = '1;
    end else begin
      total_next = total_sum[T-1:0];
    end
  end

  // Live and snapshot counters. On a capture, the live counters restart at
  // the pulses being counted on this same edge, so every event lands in
  // exactly one snapshot. Clear wins over that restart and discards the
  // pulses, but the snapshot still takes the pre-clear values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < N; c++) begin
        live_ch[c] <= '0;
        snap_ch[c] <= '0;
      end
      live_total <= '0;
      snap_total <= '0;
      ovf        <= '0;
      ovf_total  <= 1'b0;
      snap_ovf   <= '0;
    end else begin
      if (capture) begin
        for (int c = 0; c < N; c++) begin
          snap_ch[c] <= live_ch[c];
        end
        snap_total <= live_total;
        snap_ovf   <= {ovf_total, ovf};
      end
      if (clear_i) begin
        for (int c = 0; c < N; c++) begin
          live_ch[c] <= '0;
        end
        live_total <= '0;
        ovf        <= '0;
        ovf_total  <= 1'b0;
      end else if (capture) begin
        for (int c = 0; c < N; c++) begin
          live_ch[c] <= W'(p[c]);
        end
        live_total <= pop;
        ovf        <= '0;
        ovf_total  <= 1'b0;
      end else begin
        for (int c = 0; c < N; c++) begin
          live_ch[c] <= ch_next[c];
        end
        live_total <= total_next;
        ovf        <= ovf | ovf_set;
        ovf_total  <= ovf_total | total_carry;
      end
    end
  end

  // Four-phase handshake. The ack stays high until the requester drops
  // req. That forces a low-then-high req before the next capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      snap_ack_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (snap_req_i) begin
            state      <= S_ACK;
            snap_ack_o <= 1'b1;
          end
        end
        S_ACK: begin
          if (!snap_req_i) begin
            state      <= S_IDLE;
            snap_ack_o <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          snap_ack_o <= 1'b0;
        end
      endcase
    end
  end

  // Readout mux over the snapshot registers. Unused select codes read 0.
  always_comb begin
    rd_next = '0;
    for (int c = 0; c < N; c++) begin
      if (rd_sel_i == SEL_W'(c)) begin
        rd_next = T'(snap_ch[c]);
      end
    end
    if (rd_sel_i == SEL_W'(N)) begin
      rd_next = snap_total;
    end
    if (rd_sel_i == SEL_W'(N + 1)) begin
      rd_next = T'(snap_ovf);
    end
  end

  // Registered readout data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= rd_next;
    end
  end

endmodule

// File: tb/tb_radiation_monitor_multi_channel.sv
// tb_radiation_monitor_multi_channel
//
// Purpose:
//   Directed bench for radiation_monitor_multi_channel. It drives three
//   instances from shared stimulus:
//     - main:  N=8, W=16, saturating
//     - sat4:  W=4, saturating
//     - wrap4: W=4, wrapping
//   The W=4 instances are only checked in the overflow scenario.
//
// Ports:
//   none (top-level bench)
module tb_radiation_monitor_multi_channel;

  localparam int N     = 8;
  localparam int T     = 24;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     mismatch;
  logic [N-1:0]     enable;
  logic             clear;
  logic             snap_req;
  logic [SEL_W-1:0] rd_sel;
  logic             ack_a, ack_b, ack_c;
  logic [T-1:0]     rd_a, rd_b, rd_c;
  logic             ev_a, ev_b, ev_c;

  int checks = 0;
  int passes = 0;
  int ev_count;

  always #5 clk = ~clk;

  radiation_monitor_multi_channel #(
    .G_NUM_CHANNELS(8), .G_COUNTER_WIDTH(16), .G_TOTAL_WIDTH(24),
    .G_COUNTER_IS_SATURATING(1'b1)
  ) dut_main (
    .clk_i(clk), .rst_ni(rst_n), .mismatch_i(mismatch), .enable_i(enable),
    .clear_i(clear), .snap_req_i(snap_req), .snap_ack_o(ack_a),
    .rd_sel_i(rd_sel), .rd_data_o(rd_a), .event_o(ev_a)
  );

  radiation_monitor_multi_channel #(
    .G_NUM_CHANNELS(8), .G_COUNTER_WIDTH(4), .G_TOTAL_WIDTH(24),
    .G_COUNTER_IS_SATURATING(1'b1)
  ) dut_sat4 (
    .clk_i(clk), .rst_ni(rst_n), .mismatch_i(mismatch), .enable_i(enable),
    .clear_i(clear), .snap_req_i(snap_req), .snap_ack_o(ack_b),
    .rd_sel_i(rd_sel), .rd_data_o(rd_b), .event_o(ev_b)
  );

  radiation_monitor_multi_channel #(
    .G_NUM_CHANNELS(8), .G_COUNTER_WIDTH(4), .G_TOTAL_WIDTH(24),
    .G_COUNTER_IS_SATURATING(1'b0)
  ) dut_wrap4 (
    .clk_i(clk), .rst_ni(rst_n), .mismatch_i(mismatch), .enable_i(enable),
    .clear_i(clear), .snap_req_i(snap_req), .snap_ack_o(ack_c),
    .rd_sel_i(rd_sel), .rd_data_o(rd_c), .event_o(ev_c)
  );

  // Count one comparison, and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock. Sampling happens just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the mismatch, enable and clear inputs, then advance one clock.
  task automatic applyStimulus(input logic [N-1:0] mm, input logic [N-1:0] en,
                               input logic clr);
    mismatch = mm;
    enable   = en;
    clear    = clr;
    step();
  endtask

  // Set the readout select and wait out its one-cycle latency.
  task automatic readSel(input logic [SEL_W-1:0] sel);
    rd_sel = sel;
    step();
  endtask

  // Full four-phase handshake. Each wait is bounded to a few cycles.
  task automatic doSnapshot();
    snap_req = 1'b1;
    for (int i = 0; i < 8 && !ack_a; i++) step();
    checkOutput("snap_ack_rise", 32'(ack_a), 32'd1);
    snap_req = 1'b0;
    for (int i = 0; i < 8 && ack_a; i++) step();
    checkOutput("snap_ack_fall", 32'(ack_a), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    mismatch = '0;
    enable   = '1;
    clear    = 1'b0;
    snap_req = 1'b0;
    rd_sel   = '0;
    step();
    step();
    checkOutput("reset_ack", 32'(ack_a), 32'd0);
    checkOutput("reset_rd", 32'(rd_a), 32'd0);
    checkOutput("reset_event", 32'(ev_a), 32'd0);
    rst_n = 1'b1;
    step();

    // 1) Single pulse on ch3.
    applyStimulus(8'h08, 8'hFF, 1'b0);
    checkOutput("t1_event_hi", 32'(ev_a), 32'd1);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    checkOutput("t1_event_lo", 32'(ev_a), 32'd0);
    step();
    doSnapshot();
    readSel(4'd3);  checkOutput("t1_ch3", 32'(rd_a), 32'd1);
    readSel(4'd8);  checkOutput("t1_total", 32'(rd_a), 32'd1);
    readSel(4'd0);  checkOutput("t1_ch0", 32'(rd_a), 32'd0);
    readSel(4'd7);  checkOutput("t1_ch7", 32'(rd_a), 32'd0);
    readSel(4'd9);  checkOutput("t1_ovf", 32'(rd_a), 32'd0);
    readSel(4'd15); checkOutput("t1_badsel", 32'(rd_a), 32'd0);

    // 2) A held level counts once. Then 20 cycles of toggling give 10 edges.
    ev_count = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(8'h01, 8'hFF, 1'b0);
      if (ev_a) ev_count++;
    end
    checkOutput("t2_hold_events", 32'(ev_count), 32'd1);
    doSnapshot();
    readSel(4'd0); checkOutput("t2_hold_ch0", 32'(rd_a), 32'd1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 2 == 1) ? 8'h01 : 8'h00, 8'hFF, 1'b0);
    end
    applyStimulus(8'h00, 8'hFF, 1'b0);
    step();
    doSnapshot();
    readSel(4'd0); checkOutput("t2_toggle_ch0", 32'(rd_a), 32'd10);
    readSel(4'd8); checkOutput("t2_toggle_total", 32'(rd_a), 32'd10);

    // 3) Edges on a disabled channel are lost.
    ev_count = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i % 2 == 0) ? 8'h20 : 8'h00, 8'hDF, 1'b0);
      if (ev_a) ev_count++;
    end
    step();
    checkOutput("t3_no_events", 32'(ev_count), 32'd0);
    doSnapshot();
    readSel(4'd5); checkOutput("t3_ch5", 32'(rd_a), 32'd0);
    readSel(4'd8); checkOutput("t3_total", 32'(rd_a), 32'd0);
    enable = 8'hFF;

    // 4) Overflow on the W=4 counters. Saturating gives 15, wrapping gives 20 mod 16 = 4.
    applyStimulus(8'h00, 8'hFF, 1'b1);
    clear = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus((i % 2 == 0) ? 8'h02 : 8'h00, 8'hFF, 1'b0);
    end
    step();
    step();
    doSnapshot();
    readSel(4'd1);
    checkOutput("t4_main_ch1", 32'(rd_a), 32'd20);
    checkOutput("t4_sat4_ch1", 32'(rd_b), 32'd15);
    checkOutput("t4_wrap4_ch1", 32'(rd_c), 32'd4);
    readSel(4'd9);
    checkOutput("t4_main_ovf", 32'(rd_a), 32'h000);
    checkOutput("t4_sat4_ovf", 32'(rd_b), 32'h002);
    checkOutput("t4_wrap4_ovf", 32'(rd_c), 32'h002);
    readSel(4'd8);
    checkOutput("t4_wrap4_total", 32'(rd_c), 32'd20);

    // 5) All channels rise on the capture edge. They are excluded from this
    //    snapshot and included in the next one.
    mismatch = 8'hFF;
    snap_req = 1'b1;
    step();
    checkOutput("t5_ack", 32'(ack_a), 32'd1);
    checkOutput("t5_event", 32'(ev_a), 32'd1);
    snap_req = 1'b0;
    mismatch = 8'h00;
    step();
    step();
    readSel(4'd4); checkOutput("t5_snapA_ch4", 32'(rd_a), 32'd0);
    readSel(4'd8); checkOutput("t5_snapA_total", 32'(rd_a), 32'd0);
    doSnapshot();
    readSel(4'd0); checkOutput("t5_snapB_ch0", 32'(rd_a), 32'd1);
    readSel(4'd7); checkOutput("t5_snapB_ch7", 32'(rd_a), 32'd1);
    readSel(4'd8); checkOutput("t5_snapB_total", 32'(rd_a), 32'd8);

    // 5b) A pulse that is counted on the capture edge seeds the restarted counter.
    applyStimulus(8'h04, 8'hFF, 1'b0);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    mismatch = 8'h00;
    step();
    step();
    readSel(4'd2); checkOutput("t5b_snapA_ch2", 32'(rd_a), 32'd0);
    doSnapshot();
    readSel(4'd2); checkOutput("t5b_snapB_ch2", 32'(rd_a), 32'd1);
    readSel(4'd8); checkOutput("t5b_snapB_total", 32'(rd_a), 32'd1);

    // 6) Clear on the capture edge: the snapshot keeps the prior counts.
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? 8'h10 : 8'h00, 8'hFF, 1'b0);
    end
    step();
    clear    = 1'b1;
    snap_req = 1'b1;
    step();
    checkOutput("t6_ack", 32'(ack_a), 32'd1);
    clear    = 1'b0;
    snap_req = 1'b0;
    step();
    readSel(4'd4); checkOutput("t6_snapA_ch4", 32'(rd_a), 32'd3);
    readSel(4'd8); checkOutput("t6_snapA_total", 32'(rd_a), 32'd3);
    doSnapshot();
    readSel(4'd4); checkOutput("t6_snapB_ch4", 32'(rd_a), 32'd0);
    readSel(4'd8); checkOutput("t6_snapB_total", 32'(rd_a), 32'd0);

    // 6b) Reset asserted while in ACK returns everything to 0 immediately.
    applyStimulus(8'h40, 8'hFF, 1'b0);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    step();
    snap_req = 1'b1;
    step();
    checkOutput("t6b_ack", 32'(ack_a), 32'd1);
    readSel(4'd6);
    checkOutput("t6b_ch6", 32'(rd_a), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6b_rst_ack", 32'(ack_a), 32'd0);
    checkOutput("t6b_rst_rd", 32'(rd_a), 32'd0);
    snap_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    readSel(4'd6);
    checkOutput("t6b_post_ch6", 32'(rd_a), 32'd0);
    checkOutput("t6b_post_ack", 32'(ack_a), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
